// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, types and width helper for the synchronous FIFO
// Contents:
//   DEF_*     default parameter values for fifo_sync
//   fifo_op_e accepted-operation code for one clock cycle {push, pop}
//   clog2     ceiling log2, minimum result 1 (used for pointer and count widths)
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_FWFT       = 0;
    localparam int DEF_AE_LEVEL   = 2;

    // Bit 1 = accepted write, bit 0 = accepted read.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Width needed to index 'value' distinct states; never returns 0.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - modulo-DEPTH wrapping pointer
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset, forces ptr to 0
//   advance  step the pointer by one, wrapping DEPTH-1 -> 0
//   ptr      current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Explicit wrap compare so non-power-of-two depths stay in range.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with registered or fall-through read
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   W_DATA, WEN                 write word and write request
//   R_DATA, REN                 read word and read (pop) request
//   FULL, EMPTY                 occupancy == DEPTH / == 0
//   ALMOST_FULL, ALMOST_EMPTY   occupancy >= AF_LEVEL / <= AE_LEVEL
//   COUNT                       current occupancy
//   OVERFLOW, UNDERFLOW         sticky: a write hit FULL / a read hit EMPTY
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FWFT       = DEF_FWFT,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = DEF_AE_LEVEL,
    localparam int CW        = clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    input  logic                  WEN,
    output logic [DATA_WIDTH-1:0] R_DATA,
    input  logic                  REN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CW-1:0]         COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int            PW         = clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_accept;
    logic                  rd_accept;
    fifo_op_e              op;

    // Acceptance uses the flags as they stand before the edge, so a pop
    // in the same cycle never makes room for a write to a full FIFO.
    assign wr_accept = WEN && !FULL;
    assign rd_accept = REN && !EMPTY;
    assign op        = fifo_op_e'({wr_accept, rd_accept});

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk     (CLK),
        .reset   (RST),
        .advance (wr_accept),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk     (CLK),
        .reset   (RST),
        .advance (rd_accept),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared by reset; the pointers make old words unreachable.
    always_ff @(posedge CLK) begin
        if (!RST && wr_accept) begin
            mem[wr_ptr] <= W_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WEN && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (REN && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end

    assign COUNT        = count;
    assign FULL         = (count == FULL_COUNT);
    assign EMPTY        = (count == '0);
    assign ALMOST_FULL  = (count >= AF_COUNT);
    assign ALMOST_EMPTY = (count <= AE_COUNT);

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible directly; zero while empty so the output
            // matches the reset value instead of exposing stale storage.
            assign R_DATA = EMPTY ? '0 : mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_data_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_data_q <= '0;
                end else if (rd_accept) begin
                    r_data_q <= mem[rd_ptr];
                end
            end

            assign R_DATA = r_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - self-checking bench for fifo_sync against a queue model
module tb_fifo_sync;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst   [N];
    logic       wen   [N];
    logic       ren   [N];
    logic [7:0] wdata [N];
    logic [7:0] rdata [N];
    logic       full  [N];
    logic       empty [N];
    logic       af    [N];
    logic       ae    [N];
    logic       ovf   [N];
    logic       unf   [N];
    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    logic [4:0] cnt_c;

    int depth_of [N] = '{16, 5, 16};
    int af_of    [N] = '{14, 3, 14};
    int ae_of    [N] = '{2, 2, 2};
    int fwft_of  [N] = '{0, 0, 1};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] m_rd  [N];
    bit         m_ovf [N];
    bit         m_unf [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .CLK(clk), .RST(rst[0]), .W_DATA(wdata[0]), .WEN(wen[0]), .R_DATA(rdata[0]),
        .REN(ren[0]), .FULL(full[0]), .EMPTY(empty[0]), .ALMOST_FULL(af[0]),
        .ALMOST_EMPTY(ae[0]), .COUNT(cnt_a), .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0])
    );

    fifo_sync #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) dut_b (
        .CLK(clk), .RST(rst[1]), .W_DATA(wdata[1]), .WEN(wen[1]), .R_DATA(rdata[1]),
        .REN(ren[1]), .FULL(full[1]), .EMPTY(empty[1]), .ALMOST_FULL(af[1]),
        .ALMOST_EMPTY(ae[1]), .COUNT(cnt_b), .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1])
    );

    fifo_sync #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut_c (
        .CLK(clk), .RST(rst[2]), .W_DATA(wdata[2]), .WEN(wen[2]), .R_DATA(rdata[2]),
        .REN(ren[2]), .FULL(full[2]), .EMPTY(empty[2]), .ALMOST_FULL(af[2]),
        .ALMOST_EMPTY(ae[2]), .COUNT(cnt_c), .OVERFLOW(ovf[2]), .UNDERFLOW(unf[2])
    );

    function automatic logic [4:0] cnt_of(input int i);
        case (i)
            0:       return cnt_a;
            1:       return {2'b00, cnt_b};
            default: return cnt_c;
        endcase
    endfunction

    function automatic int mdl_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] mdl_head(input int i);
        if (mdl_size(i) == 0) return 8'h00;
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic mdl_push(input int i, input logic [7:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic mdl_pop(input int i, output logic [7:0] v);
        case (i)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic mdl_reset(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
        m_rd[i]  = 8'h00;
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
    endtask

    // Drive one cycle on FIFO i, advance the model by the same rules, return #1 after the edge.
    task automatic step(input int i, input bit r_st, input bit w, input bit r, input logic [7:0] d);
        int         sz;
        bit         m_full;
        bit         m_empty;
        logic [7:0] popped;
        @(negedge clk);
        rst[i]   = r_st;
        wen[i]   = w;
        ren[i]   = r;
        wdata[i] = d;
        @(posedge clk);
        sz      = mdl_size(i);
        m_full  = (sz == depth_of[i]);
        m_empty = (sz == 0);
        if (r_st) begin
            mdl_reset(i);
        end else begin
            if (w && m_full)  m_ovf[i] = 1'b1;
            if (r && m_empty) m_unf[i] = 1'b1;
            if (r && !m_empty) begin
                mdl_pop(i, popped);
                if (fwft_of[i] == 0) m_rd[i] = popped;
            end
            if (w && !m_full) mdl_push(i, d);
        end
        #1;
        rst[i] = 1'b0;
        wen[i] = 1'b0;
        ren[i] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; wen[i] = 1'b1; ren[i] = 1'b1; wdata[i] = 8'hFF;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            mdl_reset(i);
            rst[i] = 1'b0; wen[i] = 1'b0; ren[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (cnt_of(i) !== 5'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d expected 0", i, cnt_of(i)); end
            checks++; if (empty[i] !== 1'b1) begin errors++; $display("FAIL reset_empty dut%0d: got %b expected 1", i, empty[i]); end
            checks++; if (ae[i] !== 1'b1) begin errors++; $display("FAIL reset_almost_empty dut%0d: got %b expected 1", i, ae[i]); end
            checks++; if (full[i] !== 1'b0) begin errors++; $display("FAIL reset_full dut%0d: got %b expected 0", i, full[i]); end
            checks++; if (af[i] !== 1'b0) begin errors++; $display("FAIL reset_almost_full dut%0d: got %b expected 0", i, af[i]); end
            checks++; if (ovf[i] !== 1'b0 || unf[i] !== 1'b0) begin errors++; $display("FAIL reset_sticky dut%0d: got ovf=%b unf=%b expected 0/0", i, ovf[i], unf[i]); end
            if (fwft_of[i] == 0) begin
                checks++; if (rdata[i] !== 8'h00) begin errors++; $display("FAIL reset_rdata dut%0d: got %0h expected 0", i, rdata[i]); end
            end
        end
    endtask

    task automatic test_fill_drain();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 1, 0, 8'(k));
            checks++; if (cnt_a !== 5'(k)) begin errors++; $display("FAIL fill_count k=%0d: got %0d expected %0d", k, cnt_a, k); end
            checks++; if (full[0] !== (k == 16)) begin errors++; $display("FAIL fill_full k=%0d: got %b expected %b", k, full[0], (k == 16)); end
        end
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 1, 8'h00);
            checks++; if (rdata[0] !== 8'(k)) begin errors++; $display("FAIL drain_data k=%0d: got %0h expected %0h", k, rdata[0], k); end
            checks++; if (cnt_a !== 5'(16 - k)) begin errors++; $display("FAIL drain_count k=%0d: got %0d expected %0d", k, cnt_a, 16 - k); end
        end
        checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty[0]); end
        checks++; if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin errors++; $display("FAIL drain_sticky: got ovf=%b unf=%b expected 0/0", ovf[0], unf[0]); end
    endtask

    task automatic test_full_both();
        logic [7:0] stored [16];
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            stored[k] = 8'($urandom);
            step(0, 0, 1, 0, stored[k]);
        end
        step(0, 0, 1, 1, 8'hEE);
        checks++; if (cnt_a !== 5'd15) begin errors++; $display("FAIL full_both_count: got %0d expected 15", cnt_a); end
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL full_both_overflow: got %b expected 1", ovf[0]); end
        checks++; if (rdata[0] !== stored[0]) begin errors++; $display("FAIL full_both_rdata: got %0h expected %0h", rdata[0], stored[0]); end
        for (int k = 1; k < 16; k++) begin
            step(0, 0, 0, 1, 8'h00);
            checks++; if (rdata[0] !== stored[k]) begin errors++; $display("FAIL full_both_order k=%0d: got %0h expected %0h", k, rdata[0], stored[k]); end
        end
        checks++; if (empty[0] !== 1'b1 || ovf[0] !== 1'b1) begin errors++; $display("FAIL full_both_end: got empty=%b ovf=%b expected 1/1", empty[0], ovf[0]); end
    endtask

    task automatic test_empty_both();
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h3C);
        checks++; if (cnt_a !== 5'd1) begin errors++; $display("FAIL empty_both_count: got %0d expected 1", cnt_a); end
        checks++; if (unf[0] !== 1'b1 || ovf[0] !== 1'b0) begin errors++; $display("FAIL empty_both_sticky: got unf=%b ovf=%b expected 1/0", unf[0], ovf[0]); end
        checks++; if (rdata[0] !== 8'h00) begin errors++; $display("FAIL empty_both_rdata_hold: got %0h expected 0", rdata[0]); end
        step(0, 0, 0, 1, 8'h00);
        checks++; if (rdata[0] !== 8'h3C || cnt_a !== 5'd0) begin errors++; $display("FAIL empty_both_pop: got %0h/%0d expected 3c/0", rdata[0], cnt_a); end
        step(0, 0, 0, 1, 8'h00);
        checks++; if (rdata[0] !== 8'h3C) begin errors++; $display("FAIL underflow_rdata_hold: got %0h expected 3c", rdata[0]); end
    endtask

    task automatic test_wrap();
        int nw;
        int nr;
        nw = 0;
        nr = 0;
        step(1, 1, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 1, 0, 8'(8'h40 + nw)); nw++;
        end
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 1, 1, 8'(8'h40 + nw)); nw++;
            checks++; if (rdata[1] !== 8'(8'h40 + nr)) begin errors++; $display("FAIL wrap_data k=%0d: got %0h expected %0h", k, rdata[1], 8'h40 + nr); end
            nr++;
            checks++; if (cnt_b !== 3'd4) begin errors++; $display("FAIL wrap_count k=%0d: got %0d expected 4", k, cnt_b); end
        end
        step(1, 0, 1, 0, 8'(8'h40 + nw)); nw++;
        checks++; if (full[1] !== 1'b1 || cnt_b !== 3'd5) begin errors++; $display("FAIL wrap_full: got full=%b count=%0d expected 1/5", full[1], cnt_b); end
        step(1, 0, 1, 0, 8'hDD);
        checks++; if (cnt_b !== 3'd5 || ovf[1] !== 1'b1) begin errors++; $display("FAIL wrap_overflow: got count=%0d ovf=%b expected 5/1", cnt_b, ovf[1]); end
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, 1, 8'h00);
            checks++; if (rdata[1] !== 8'(8'h40 + nr)) begin errors++; $display("FAIL wrap_drain k=%0d: got %0h expected %0h", k, rdata[1], 8'h40 + nr); end
            nr++;
        end
        checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty[1]); end
    endtask

    task automatic test_thresholds();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 1, 0, 8'(k + 8'h20));
            checks++; if (af[0] !== (k >= 14)) begin errors++; $display("FAIL af_rise n=%0d: got %b expected %b", k, af[0], (k >= 14)); end
            checks++; if (ae[0] !== (k <= 2)) begin errors++; $display("FAIL ae_fall n=%0d: got %b expected %b", k, ae[0], (k <= 2)); end
        end
        for (int k = 14; k >= 9; k--) begin
            step(0, 0, 0, 1, 8'h00);
            checks++; if (af[0] !== (k >= 14) || cnt_a !== 5'(k)) begin errors++; $display("FAIL af_drop n=%0d: got af=%b count=%0d expected %b/%0d", k, af[0], cnt_a, (k >= 14), k); end
        end
        step(0, 1, 1, 1, 8'h99);
        checks++; if (cnt_a !== 5'd0 || empty[0] !== 1'b1 || ae[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_flags: got count=%0d empty=%b ae=%b expected 0/1/1", cnt_a, empty[0], ae[0]); end
        checks++; if (full[0] !== 1'b0 || af[0] !== 1'b0 || rdata[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_rest: got full=%b af=%b rdata=%0h expected 0/0/0", full[0], af[0], rdata[0]); end
        step(0, 0, 1, 0, 8'h5C);
        step(0, 0, 0, 1, 8'h00);
        checks++; if (rdata[0] !== 8'h5C || empty[0] !== 1'b1) begin errors++; $display("FAIL post_reset_first: got %0h empty=%b expected 5c/1", rdata[0], empty[0]); end
    endtask

    task automatic test_fwft();
        step(2, 1, 0, 0, 8'h00);
        step(2, 0, 1, 0, 8'hA5);
        checks++; if (empty[2] !== 1'b0 || rdata[2] !== 8'hA5) begin errors++; $display("FAIL fwft_first: got empty=%b rdata=%0h expected 0/a5", empty[2], rdata[2]); end
        step(2, 0, 1, 0, 8'h5A);
        checks++; if (rdata[2] !== 8'hA5 || cnt_c !== 5'd2) begin errors++; $display("FAIL fwft_hold: got %0h/%0d expected a5/2", rdata[2], cnt_c); end
        step(2, 0, 0, 1, 8'h00);
        checks++; if (rdata[2] !== 8'h5A || cnt_c !== 5'd1) begin errors++; $display("FAIL fwft_pop: got %0h/%0d expected 5a/1", rdata[2], cnt_c); end
        step(2, 0, 1, 1, 8'h77);
        checks++; if (rdata[2] !== 8'h77 || cnt_c !== 5'd1) begin errors++; $display("FAIL fwft_both: got %0h/%0d expected 77/1", rdata[2], cnt_c); end
        step(2, 0, 0, 1, 8'h00);
        checks++; if (empty[2] !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b expected 1", empty[2]); end
    endtask

    task automatic test_random();
        int  pw;
        int  pr;
        int  sz;
        for (int i = 0; i < N; i++) begin
            step(i, 1, 0, 0, 8'h00);
            for (int c = 0; c < 300; c++) begin
                pw = ((c / 60) % 2 == 0) ? 75 : 30;
                pr = 100 - pw;
                step(i, ($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < pw),
                     ($urandom_range(0, 99) < pr), 8'($urandom));
                sz = mdl_size(i);
                checks++; if (cnt_of(i) !== 5'(sz)) begin errors++; $display("FAIL rnd_count dut%0d c=%0d: got %0d expected %0d", i, c, cnt_of(i), sz); end
                checks++; if (full[i] !== (sz == depth_of[i]) || empty[i] !== (sz == 0)) begin errors++; $display("FAIL rnd_full_empty dut%0d c=%0d: got %b%b expected %b%b", i, c, full[i], empty[i], (sz == depth_of[i]), (sz == 0)); end
                checks++; if (af[i] !== (sz >= af_of[i]) || ae[i] !== (sz <= ae_of[i])) begin errors++; $display("FAIL rnd_almost dut%0d c=%0d: got af=%b ae=%b expected %b/%b", i, c, af[i], ae[i], (sz >= af_of[i]), (sz <= ae_of[i])); end
                checks++; if (ovf[i] !== m_ovf[i] || unf[i] !== m_unf[i]) begin errors++; $display("FAIL rnd_sticky dut%0d c=%0d: got %b%b expected %b%b", i, c, ovf[i], unf[i], m_ovf[i], m_unf[i]); end
                if (fwft_of[i] == 0) begin
                    checks++; if (rdata[i] !== m_rd[i]) begin errors++; $display("FAIL rnd_rdata dut%0d c=%0d: got %0h expected %0h", i, c, rdata[i], m_rd[i]); end
                end else if (sz != 0) begin
                    checks++; if (rdata[i] !== mdl_head(i)) begin errors++; $display("FAIL rnd_head dut%0d c=%0d: got %0h expected %0h", i, c, rdata[i], mdl_head(i)); end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; wen[i] = 1'b0; ren[i] = 1'b0; wdata[i] = 8'h00;
        end
        test_reset();
        test_fill_drain();
        test_full_both();
        test_empty_both();
        test_wrap();
        test_thresholds();
        test_fwft();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, storage depth in words; legal values are any integer >= 2, power of two not required.
REQ-003 The module SHALL have parameter FWFT, default 0; 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-004 The module SHALL have parameter AF_LEVEL, default DEPTH-2, the almost-full threshold; legal range is 1..DEPTH.
REQ-005 The module SHALL have parameter AE_LEVEL, default 2, the almost-empty threshold; legal range is 0..DEPTH-1.
REQ-006 The module SHALL use one clock and a synchronous, active-high reset: CLK  in  1  sole clock, all logic on rising edge; RST  in  1  synchronous active-high reset.
REQ-007 The module SHALL have W_DATA  in  DATA_WIDTH  write word.
REQ-008 The module SHALL have WEN  in  1  write request.
REQ-009 The module SHALL have R_DATA  out  DATA_WIDTH  read word.
REQ-010 The module SHALL have REN  in  1  read request (pop).
REQ-011 The module SHALL have FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY, each out, 1 bit, as occupancy flags.
REQ-012 The module SHALL have COUNT  out  CW  occupancy, where CW = clog2(DEPTH+1).
REQ-013 The module SHALL have OVERFLOW and UNDERFLOW, each out, 1 bit, as sticky error flags.

Function
REQ-014 A write SHALL be accepted when WEN=1 and FULL=0, storing W_DATA at the write pointer.
REQ-015 A read SHALL be accepted when REN=1 and EMPTY=0, advancing the read pointer.
REQ-016 Flags SHALL be sampled at the start of the cycle; WEN with FULL=1 is rejected even when a read is accepted in the same cycle.
REQ-017 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 COUNT SHALL be +1 on a write only, -1 on a read only, and unchanged on both or neither, updating on the accepting edge.
REQ-019 Flags SHALL be FULL = (COUNT==DEPTH), EMPTY = (COUNT==0), ALMOST_FULL = (COUNT>=AF_LEVEL) and ALMOST_EMPTY = (COUNT<=AE_LEVEL), and SHALL change on the same edge as COUNT.
REQ-020 When FWFT=0, R_DATA SHALL be registered: it shows the popped word on the edge after an accepted read and holds its value otherwise.
REQ-021 When FWFT=1, R_DATA SHALL show the head word combinationally whenever EMPTY=0, is don't-care when EMPTY=1, and the next word appears on the edge that accepts REN.
REQ-022 Write-to-EMPTY-deassert latency SHALL be 1 edge in both modes.
REQ-023 A rejected WEN SHALL set OVERFLOW and a rejected REN SHALL set UNDERFLOW; both flags clear only on reset.
REQ-024 A rejected request SHALL change no pointer, COUNT, memory location or R_DATA.

Reset
REQ-025 While RST=1 at an edge, COUNT, both pointers, R_DATA, OVERFLOW and UNDERFLOW SHALL go to 0, with EMPTY=1, ALMOST_EMPTY=1, FULL=0 and ALMOST_FULL=0.
REQ-026 Reset SHALL override WEN and REN in the same cycle; storage contents are not cleared.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; the first read after reset returns the first word written after reset.

Structure
REQ-028 Package fifo_pkg SHALL hold the default parameter constants and the count-width function clog2(DEPTH+1).
REQ-029 Sub-module fifo_ptr SHALL implement the wrapping modulo-DEPTH pointer (inputs: advance, reset) and be instantiated for both read and write pointers.
REQ-030 Storage SHALL be a flop array of DEPTH x DATA_WIDTH.

Verification
REQ-031 With DEPTH=16 and FWFT=0, writing 0x01..0x10 then reading 16 SHALL give FULL=1 after the 16th write, COUNT=16, R_DATA 0x01..0x10 in order, then EMPTY=1.
REQ-032 With DEPTH=5 (non-power-of-two), 12 write/read pairs SHALL wrap the pointers with data in order and COUNT never above 5.
REQ-033 When full, WEN+REN in the same cycle SHALL accept the read, reject the write, give COUNT=DEPTH-1 and OVERFLOW=1.
REQ-034 When empty, WEN+REN in the same cycle SHALL accept the write, reject the read, give COUNT=1 and UNDERFLOW=1.
REQ-035 With FWFT=1, writing 0xA5 into an empty FIFO SHALL give EMPTY=0 and R_DATA=0xA5 one edge later with no REN.
REQ-036 With AF_LEVEL=14 and AE_LEVEL=2, ALMOST_FULL SHALL rise at COUNT=14, ALMOST_EMPTY SHALL fall at COUNT=3, and RST at COUNT=9 SHALL restore all reset values next edge.
